// File: rtl/alu_sequencer.sv
// Program-memory driven ALU sequencer: runs instructions 0..len-1 after start and
// streams each result with {N, V, C, Z} flags over a valid/ready handshake.
module alu_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned IW = 3 + 2 * WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             prog_we_i,
  input  logic [AW-1:0]    prog_addr_i,
  input  logic [IW-1:0]    prog_data_i,
  input  logic [AW:0]      prog_len_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic [3:0]       res_flags_o,
  output logic [AW-1:0]    res_addr_o
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StOut, StDone} state_e;

  localparam logic [AW:0] LenMax = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LenOne = {{AW{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW:0]      len_q, len_d, len_clamped;
  logic             last_instr;
  logic [IW-1:0]    mem [DEPTH];
  logic [IW-1:0]    instr_q;
  logic [WIDTH-1:0] res_data_q, alu_res;
  logic [3:0]       res_flags_q, alu_flags;
  logic [AW-1:0]    res_addr_q;

  logic [2:0]       op;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH:0]   sum, diff;
  logic             carry, ovf;

  assign len_clamped = (prog_len_i > LenMax) ? LenMax : prog_len_i;
  assign last_instr  = ({1'b0, pc_q} == (len_q - LenOne));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d   = len_clamped;
          pc_d    = '0;
          state_d = (len_clamped == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StExec;
      StExec:  state_d = StOut;
      StOut: begin
        if (res_ready_i) begin
          if (last_instr) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
    res_valid_o = (state_q == StOut);
  end

  assign res_data_o  = res_data_q;
  assign res_flags_o = res_flags_q;
  assign res_addr_o  = res_addr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q        <= '0;
      len_q       <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_addr_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      len_q <= len_d;
      if (state_q == StExec) begin
        res_data_q  <= alu_res;
        res_flags_q <= alu_flags;
        res_addr_q  <= pc_q;
      end
    end
  end

  // Program memory is deliberately outside reset so a reset mid-run keeps the program.
  always_ff @(posedge clk_i) begin
    if (prog_we_i && (state_q == StIdle)) begin
      mem[prog_addr_i] <= prog_data_i;
    end
    if (state_q == StFetch) begin
      instr_q <= mem[pc_q];
    end
  end

  always_comb begin
    op    = instr_q[IW-1 -: 3];
    opa   = instr_q[2*WIDTH-1 -: WIDTH];
    opb   = instr_q[WIDTH-1:0];
    sum   = {1'b0, opa} + {1'b0, opb};
    diff  = {1'b0, opa} - {1'b0, opb};
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        carry   = sum[WIDTH];
        ovf     = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff[WIDTH-1:0];
        carry   = diff[WIDTH];
        ovf     = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      // Shift amounts of WIDTH or more fall out of range and yield zero.
      3'b010:  alu_res = opa << opb;
      3'b011:  alu_res = opa >> opb;
      3'b100:  alu_res = opa & opb;
      3'b101:  alu_res = opa | opb;
      3'b110:  alu_res = opa ^ opb;
      default: alu_res = ~opa;
    endcase
    alu_flags = {alu_res[WIDTH-1], ovf, carry, (alu_res == '0)};
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table vectors, hand-written handshake/reset
// sequences and randomized programs scored against an arithmetic reference model.
module tb_alu_sequencer;
  localparam int W  = 8;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int IW = 19;
  localparam int NV = 15;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          prog_we_i;
  logic [AW-1:0] prog_addr_i;
  logic [IW-1:0] prog_data_i;
  logic [AW:0]   prog_len_i;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [W-1:0]  res_data_o;
  logic [3:0]    res_flags_o;
  logic [AW-1:0] res_addr_o;

  int total = 0;
  int bad   = 0;

  logic [IW-1:0] mem_m [D];
  logic [7:0]    exp_d [D];
  logic [3:0]    exp_f [D];

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;
  vec_t tbl [NV];

  alu_sequencer dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i),
    .prog_len_i  (prog_len_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .res_flags_o (res_flags_o),
    .res_addr_o  (res_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_mem(input int addr, input logic [IW-1:0] w);
    prog_we_i   = 1'b1;
    prog_addr_i = AW'(addr);
    prog_data_i = w;
    step();
    prog_we_i   = 1'b0;
    mem_m[addr] = w;
  endtask

  // Reference ALU from plain integer arithmetic; returns {flags, result}.
  function automatic logic [11:0] ref_alu(input logic [IW-1:0] w);
    int op = int'(w[18:16]);
    int a  = int'(w[15:8]);
    int b  = int'(w[7:0]);
    int sa = (a > 127) ? a - 256 : a;
    int sb = (b > 127) ? b - 256 : b;
    int r  = 0;
    int sr = 0;
    bit c  = 0;
    bit v  = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) > 255; sr = sa + sb; v = (sr > 127) || (sr < -128); end
      1: begin r = (a - b + 256) % 256; c = a < b; sr = sa - sb; v = (sr > 127) || (sr < -128); end
      2: r = (b >= 8) ? 0 : (a * (1 << b)) % 256;
      3: r = (b >= 8) ? 0 : a / (1 << b);
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = 255 - a;
    endcase
    return {(r >= 128), v, c, (r == 0), 8'(r)};
  endfunction

  task automatic fill_exp_model(input int nn);
    logic [11:0] r;
    for (int i = 0; i < nn; i++) begin
      r        = ref_alu(mem_m[i]);
      exp_f[i] = r[11:8];
      exp_d[i] = r[7:0];
    end
  endtask

  // Launches a run and checks every cycle against the expected cycle-level behaviour.
  task automatic run_check(input int n, input int ready_pct, input bit we0,
                           input logic [IW-1:0] d0);
    int  nn       = (n > D) ? D : n;
    int  idx      = 0;
    int  next_v   = 3;
    int  done_cyc = (nn == 0) ? 1 : -1;
    bit  fin      = 0;
    bit  ev;
    bit  rdy;
    start_i    = 1'b1;
    prog_len_i = (AW + 1)'(n);
    if (we0) begin
      prog_we_i   = 1'b1;
      prog_addr_i = '0;
      prog_data_i = d0;
    end
    step();
    start_i   = 1'b0;
    prog_we_i = 1'b0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      ev = (idx < nn) && (cyc >= next_v);
      check("run_valid", int'(res_valid_o), int'(ev));
      if (ev && res_valid_o) begin
        check("run_data", int'(res_data_o), int'(exp_d[idx]));
        check("run_flags", int'(res_flags_o), int'(exp_f[idx]));
        check("run_addr", int'(res_addr_o), idx);
      end
      check("run_done", int'(done_o), int'(cyc == done_cyc));
      check("run_busy", int'(busy_o), 1);
      rdy         = ($urandom_range(99) < ready_pct);
      res_ready_i = rdy;
      if (ev && rdy) begin
        idx++;
        next_v = cyc + 3;
        if (idx == nn) done_cyc = cyc + 1;
      end
      if (cyc == done_cyc) begin
        fin = 1;
        break;
      end
      step();
    end
    if (!fin) check("run_timeout", 0, 1);
    check("run_count", idx, nn);
    res_ready_i = 1'b0;
    step();
    check("run_idle_busy", int'(busy_o), 0);
    check("run_idle_done", int'(done_o), 0);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!res_valid_o && k < 20) begin
      step();
      k++;
    end
    check(nm, int'(res_valid_o), 1);
  endtask

  initial begin
    logic [IW-1:0] w;
    logic [IW-1:0] d0;
    int            n;
    int            nn;
    bit            we0;

    reset_i     = 1'b1;
    prog_we_i   = 1'b0;
    prog_addr_i = '0;
    prog_data_i = '0;
    prog_len_i  = '0;
    start_i     = 1'b0;
    res_ready_i = 1'b0;
    step();
    step();
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_valid", int'(res_valid_o), 0);
    check("rst_data", int'(res_data_o), 0);
    check("rst_flags", int'(res_flags_o), 0);
    check("rst_addr", int'(res_addr_o), 0);
    reset_i = 1'b0;
    step();

    // Flags are {N, V, C, Z}.
    tbl[0]  = '{3'd0, 8'h17, 8'h13, 8'h2A, 4'h0};
    tbl[1]  = '{3'd1, 8'h07, 8'h4C, 8'hBB, 4'hA};
    tbl[2]  = '{3'd2, 8'h1F, 8'h05, 8'hE0, 4'h8};
    tbl[3]  = '{3'd3, 8'h1F, 8'h02, 8'h07, 4'h0};
    tbl[4]  = '{3'd2, 8'h1F, 8'h09, 8'h00, 4'h1};
    tbl[5]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'hC};
    tbl[6]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'h3};
    tbl[7]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'h4};
    tbl[8]  = '{3'd4, 8'hF0, 8'h3C, 8'h30, 4'h0};
    tbl[9]  = '{3'd5, 8'h0F, 8'h80, 8'h8F, 4'h8};
    tbl[10] = '{3'd6, 8'hAA, 8'hAA, 8'h00, 4'h1};
    tbl[11] = '{3'd7, 8'h0F, 8'h55, 8'hF0, 4'h8};
    tbl[12] = '{3'd3, 8'h80, 8'h08, 8'h00, 4'h1};
    tbl[13] = '{3'd3, 8'h80, 8'h07, 8'h01, 4'h0};
    tbl[14] = '{3'd1, 8'h05, 8'h05, 8'h00, 4'h1};
    for (int i = 0; i < NV; i++) begin
      write_mem(i, {tbl[i].op, tbl[i].a, tbl[i].b});
      exp_d[i] = tbl[i].res;
      exp_f[i] = tbl[i].flags;
    end
    run_check(2, 100, 1'b0, '0);
    run_check(NV, 100, 1'b0, '0);
    run_check(NV, 40, 1'b0, '0);

    // Backpressure: result held stable, exactly one transfer per ready pulse.
    start_i    = 1'b1;
    prog_len_i = 7'd2;
    step();
    start_i = 1'b0;
    wait_valid("bp_v0");
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold_valid", int'(res_valid_o), 1);
      check("bp_hold_data", int'(res_data_o), 8'h2A);
      check("bp_hold_addr", int'(res_addr_o), 0);
    end
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("bp_drop_valid", int'(res_valid_o), 0);
    check("bp_busy", int'(busy_o), 1);
    wait_valid("bp_v1");
    check("bp_addr1", int'(res_addr_o), 1);
    check("bp_data1", int'(res_data_o), 8'hBB);
    check("bp_flags1", int'(res_flags_o), 4'hA);
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("bp_done", int'(done_o), 1);
    step();
    check("bp_idle", int'(busy_o), 0);

    run_check(0, 100, 1'b0, '0);

    // Write and start while busy are both ignored.
    start_i    = 1'b1;
    prog_len_i = 7'd1;
    step();
    prog_we_i   = 1'b1;
    prog_addr_i = '0;
    prog_data_i = 19'h70000;
    prog_len_i  = 7'd3;
    res_ready_i = 1'b1;
    step();
    step();
    prog_we_i = 1'b0;
    start_i   = 1'b0;
    check("wb_valid", int'(res_valid_o), 1);
    check("wb_data", int'(res_data_o), 8'h2A);
    step();
    res_ready_i = 1'b0;
    check("wb_done", int'(done_o), 1);
    step();
    check("wb_idle", int'(busy_o), 0);
    run_check(1, 100, 1'b0, '0);

    // Reset while presenting instruction 1 of 4.
    start_i    = 1'b1;
    prog_len_i = 7'd4;
    step();
    start_i = 1'b0;
    wait_valid("rs_v0");
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    wait_valid("rs_v1");
    check("rs_addr1", int'(res_addr_o), 1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("rs_busy", int'(busy_o), 0);
    check("rs_done", int'(done_o), 0);
    check("rs_valid", int'(res_valid_o), 0);
    check("rs_data", int'(res_data_o), 0);
    check("rs_flags", int'(res_flags_o), 0);
    check("rs_addr", int'(res_addr_o), 0);
    step();
    check("rs_no_done", int'(done_o), 0);
    run_check(4, 100, 1'b0, '0);

    // Random programs; last one exceeds DEPTH to exercise the length clamp.
    for (int it = 0; it < 6; it++) begin
      n  = (it == 5) ? 70 : int'($urandom_range(1, 10));
      nn = (n > D) ? D : n;
      for (int i = 0; i < nn; i++) begin
        w = IW'($urandom);
        if (w[18:17] == 2'b01) w[7:0] = 8'($urandom_range(0, 9));
        write_mem(i, w);
      end
      we0 = it[0];
      d0  = IW'($urandom);
      if (we0) mem_m[0] = d0;
      fill_exp_model(nn);
      run_check(n, 30 + it * 10, we0, d0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
